// File: rtl/tog_pkg.sv
// Shared definitions for the two-phase toggle receiver and its transmitter-side partner.
package tog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } tog_state_t;

    localparam int TOG_PEND_W = 4;
    localparam int TOG_CNT_W  = 8;

endpackage

// File: rtl/tog_edge_det.sv
// Toggle-line edge detector. With TOG_RX_SYNC_EN defined, a 2-flop synchronizer
// precedes the detector and edges are masked while the synchronizer refills after reset.
module tog_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_tog,
    output logic o_edge
);

`ifdef TOG_RX_SYNC_EN
    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_mask;

    // The mask spans the cycles in which r_sync2/r_prev still hold reset zeros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_mask  <= 2'd3;
        end else begin
            r_sync1 <= i_tog;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_mask != 2'd0) begin
                r_mask <= r_mask - 2'd1;
            end
        end
    end

    assign o_edge = (r_sync2 ^ r_prev) && (r_mask == 2'd0);
`else
    logic r_prev;

    // Reset primes r_prev with the live level so a high line at release is not an event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= i_tog;
        end else begin
            r_prev <= i_tog;
        end
    end

    assign o_edge = i_tog ^ r_prev;
`endif

endmodule

// File: rtl/toggle_event_rx.sv
// Two-phase toggle receiver: pulses per toggle, queues events, hands them out over
// valid/ready and returns a toggling ack. Optional input synchronizer via TOG_RX_SYNC_EN.
module toggle_event_rx
    import tog_pkg::*;
#(
    parameter int PEND_W = TOG_PEND_W,
    parameter int CNT_W  = TOG_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tog_in,
    output logic              evt_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              ack_tog,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  evt_total,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              w_edge;
    logic              w_accept;
    logic              w_ovf_set;
    logic [PEND_W-1:0] w_pend_nxt;

    logic              r_pulse;
    logic              r_ack;
    logic [PEND_W-1:0] r_pend;
    logic [CNT_W-1:0]  r_total;
    logic              r_ovf;
    tog_state_t        r_state;

    tog_edge_det u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .i_tog  (tog_in),
        .o_edge (w_edge)
    );

    always_comb begin
        w_accept   = (r_pend != '0) && evt_ready;
        w_pend_nxt = r_pend;
        w_ovf_set  = 1'b0;
        if (w_edge && !w_accept) begin
            if (r_pend == PEND_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pend_nxt = r_pend + 1'b1;
            end
        end else if (!w_edge && w_accept) begin
            w_pend_nxt = r_pend - 1'b1;
        end
    end

    // State follows the next counter value; it tracks occupancy and drives no output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pulse <= 1'b0;
            r_ack   <= 1'b0;
            r_pend  <= '0;
            r_total <= '0;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_pulse <= w_edge;
            r_pend  <= w_pend_nxt;
            if (w_accept) begin
                r_ack <= ~r_ack;
            end
            if (w_edge) begin
                r_total <= r_total + 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_pend_nxt == PEND_MAX) begin
                        r_state <= FULL;
                    end else if (w_pend_nxt != '0) begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_pend_nxt == '0) begin
                        r_state <= IDLE;
                    end else if (w_pend_nxt == PEND_MAX) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_pend_nxt == '0) begin
                        r_state <= IDLE;
                    end else if (w_pend_nxt != PEND_MAX) begin
                        r_state <= BUSY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign evt_pulse = r_pulse;
    assign evt_valid = (r_pend != '0);
    assign ack_tog   = r_ack;
    assign pend_cnt  = r_pend;
    assign evt_total = r_total;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed bench for toggle_event_rx with a 2-bit pending counter so full/overflow are reachable.
module tb_toggle_event_rx;

    localparam int PW = 2;
    localparam int CW = 8;
`ifdef TOG_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tog_in = 1'b1;
    logic          evt_ready = 1'b0;
    logic          evt_pulse;
    logic          evt_valid;
    logic          ack_tog;
    logic [PW-1:0] pend_cnt;
    logic [CW-1:0] evt_total;
    logic          overflow;

    int n_chk = 0;
    int n_err = 0;

    toggle_event_rx #(.PEND_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tog_in    (tog_in),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .ack_tog   (ack_tog),
        .pend_cnt  (pend_cnt),
        .evt_total (evt_total),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset held with line high
        cyc(5);
        chk("rst_pulse", {31'd0, evt_pulse}, 0);
        chk("rst_pend", {30'd0, pend_cnt}, 0);
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_ack", {31'd0, ack_tog}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        chk("rst_total", {24'd0, evt_total}, 0);
        reset = 1'b1;
        cyc(6);
        chk("rel_pulse", {31'd0, evt_pulse}, 0);
        chk("rel_pend", {30'd0, pend_cnt}, 0);

        // single event, consumer idle
        tog_in = ~tog_in;
        cyc(LAT);
        chk("e1_pulse", {31'd0, evt_pulse}, 1);
        chk("e1_pend", {30'd0, pend_cnt}, 1);
        chk("e1_total", {24'd0, evt_total}, 1);
        cyc(1);
        chk("e1_pulse_end", {31'd0, evt_pulse}, 0);

        evt_ready = 1'b1;
        cyc(1);
        chk("c1_pend", {30'd0, pend_cnt}, 0);
        chk("c1_ack", {31'd0, ack_tog}, 1);
        cyc(2);
        chk("idle_ready_ack", {31'd0, ack_tog}, 1);
        chk("idle_ready_pend", {30'd0, pend_cnt}, 0);
        evt_ready = 1'b0;

        // three events queued, then drained
        tog_in = ~tog_in; cyc(2);
        tog_in = ~tog_in; cyc(2);
        tog_in = ~tog_in; cyc(LAT + 1);
        chk("q3_pend", {30'd0, pend_cnt}, 3);
        chk("q3_valid", {31'd0, evt_valid}, 1);
        chk("q3_total", {24'd0, evt_total}, 4);
        chk("q3_ovf", {31'd0, overflow}, 0);
        evt_ready = 1'b1;
        cyc(1);
        chk("d1_pend", {30'd0, pend_cnt}, 2);
        chk("d1_ack", {31'd0, ack_tog}, 0);
        cyc(1);
        chk("d2_pend", {30'd0, pend_cnt}, 1);
        chk("d2_ack", {31'd0, ack_tog}, 1);
        cyc(1);
        chk("d3_pend", {30'd0, pend_cnt}, 0);
        chk("d3_ack", {31'd0, ack_tog}, 0);
        chk("d3_valid", {31'd0, evt_valid}, 0);
        evt_ready = 1'b0;

        // four events into a 3-deep counter
        for (int i = 0; i < 4; i++) begin
            tog_in = ~tog_in;
            cyc(2);
        end
        cyc(LAT);
        chk("ov_pend", {30'd0, pend_cnt}, 3);
        chk("ov_flag", {31'd0, overflow}, 1);
        chk("ov_total", {24'd0, evt_total}, 8);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("ov_acc_pend", {30'd0, pend_cnt}, 2);
        chk("ov_sticky", {31'd0, overflow}, 1);
        chk("ov_acc_ack", {31'd0, ack_tog}, 1);

        // mid-stream reset discards pending events
        reset = 1'b0;
        cyc(1);
        chk("mr_pend", {30'd0, pend_cnt}, 0);
        chk("mr_ack", {31'd0, ack_tog}, 0);
        chk("mr_ovf", {31'd0, overflow}, 0);
        chk("mr_total", {24'd0, evt_total}, 0);
        chk("mr_valid", {31'd0, evt_valid}, 0);
        chk("mr_pulse", {31'd0, evt_pulse}, 0);
        reset = 1'b1;
        cyc(4);
        tog_in = ~tog_in;
        cyc(LAT);
        chk("pr_pulse", {31'd0, evt_pulse}, 1);
        chk("pr_pend", {30'd0, pend_cnt}, 1);
        chk("pr_total", {24'd0, evt_total}, 1);

        // fill, then edge and accept in the same cycle while full
        cyc(1);
        tog_in = ~tog_in; cyc(2);
        tog_in = ~tog_in; cyc(LAT + 1);
        chk("f_pend", {30'd0, pend_cnt}, 3);
        chk("f_ovf", {31'd0, overflow}, 0);
        tog_in = ~tog_in;
        if (LAT > 1) cyc(LAT - 1);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("fa_pend", {30'd0, pend_cnt}, 3);
        chk("fa_ovf", {31'd0, overflow}, 0);
        chk("fa_ack", {31'd0, ack_tog}, 1);
        chk("fa_pulse", {31'd0, evt_pulse}, 1);
        chk("fa_total", {24'd0, evt_total}, 4);

        // total counter wrap with consumer always ready
        evt_ready = 1'b1;
        for (int i = 0; i < 251; i++) begin
            cyc(1);
            tog_in = ~tog_in;
            cyc(1);
        end
        cyc(LAT + 3);
        chk("w_total_ff", {24'd0, evt_total}, 32'hff);
        chk("w_pend", {30'd0, pend_cnt}, 0);
        chk("w_ovf", {31'd0, overflow}, 0);
        tog_in = ~tog_in;
        cyc(LAT);
        chk("w_total_0", {24'd0, evt_total}, 0);
        chk("w_pulse", {31'd0, evt_pulse}, 1);
        cyc(3);
        chk("w_drain", {30'd0, pend_cnt}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
